// File: rtl/handshake_transmitter.sv
`timescale 1ns/1ps
// handshake_transmitter
// Sending end of a 4-phase req/ack parallel link. A word taken from local
// logic over valid/ready is placed on data_out, held for SETUP_CYCLES, then
// announced with req_out. The remote side answers by raising and then
// dropping ack_in; every wait for ack is bounded by TIMEOUT_CYCLES.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset (wins over everything)
//   tx_data_in     word to send
//   tx_valid_in    tx_data_in is valid
//   tx_ready_out   block can accept a word (IDLE and not in reset)
//   data_out       link data lines, registered, loaded only on accept
//   req_out        link request, direct flop output
//   ack_in         link acknowledge, asynchronous to clk
//   busy_out       a transfer is in progress
//   done_pulse     one cycle when a transfer completes normally
//   timeout_pulse  one cycle when a transfer is aborted
module handshake_transmitter #(
   parameter int DATA_WIDTH     = 4,
   parameter int SETUP_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] tx_data_in,
   input  logic                  tx_valid_in,
   output logic                  tx_ready_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  req_out,
   input  logic                  ack_in,
   output logic                  busy_out,
   output logic                  done_pulse,
   output logic                  timeout_pulse
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMR_MAX    = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT_HI,
      S_WAIT_LO
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    req_q, req_d;
   logic                    done_q, done_d;
   logic                    tmo_q, tmo_d;
   logic                    abort_q, abort_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    ack_sync;
   logic                    accept;

   assign ack_sync      = sync_q[SYNC_STAGES-1];
   assign tx_ready_out  = (state_q == S_IDLE) && !rst;
   assign busy_out      = (state_q != S_IDLE);
   assign accept        = tx_valid_in && tx_ready_out;
   assign data_out      = data_q;
   assign req_out       = req_q;
   assign done_pulse    = done_q;
   assign timeout_pulse = tmo_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      req_d   = req_q;
      abort_d = abort_q;
      done_d  = 1'b0;
      tmo_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               data_d  = tx_data_in;
               abort_d = 1'b0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            // A stale ack left high by the previous transfer holds req back.
            if ((timer_q >= SETUP_LAST) && !ack_sync) begin
               req_d   = 1'b1;
               state_d = S_WAIT_HI;
            end else if (timer_q == TMO_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WAIT_HI: begin
            if (ack_sync) begin
               req_d   = 1'b0;
               state_d = S_WAIT_LO;
            end else if (timer_q == TMO_LAST) begin
               // Abort, but still let the remote side finish its ack cycle.
               req_d   = 1'b0;
               tmo_d   = 1'b1;
               abort_d = 1'b1;
               state_d = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            // The abort flag keeps an aborted transfer to a single pulse.
            if (!ack_sync) begin
               done_d  = !abort_q;
               state_d = S_IDLE;
            end else if (timer_q == TMO_LAST) begin
               tmo_d   = !abort_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Phase timer restarts on every state change and saturates.
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q == TMR_MAX) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
         abort_q <= 1'b0;
         timer_q <= '0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         req_q   <= req_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
         abort_q <= abort_d;
         timer_q <= timer_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_in};
      end
   end

endmodule
